lora_gps_frame_ctrl: RTL and testbench
======================================

// Module: lora_gps_frame_ctrl
// PURPOSE
//  Sequences the shared GPS/LoRa frame RAM (dual-port, 1 write/read port A, 1 read port B, registered address).
//  - Write side: hunts GPS UART bytes for an NMEA sentence ('$' .. LF) and writes it into RAM via port A.
//  - Read side: once a full sentence is stored, streams it out of port B to the LoRa UART transmitter.
//  - Single-buffer ping: capture and transmit never overlap. Sits between the GPS rx, the RAM and the LoRa tx.
// PARAMETERS
//  ADDR_WIDTH  6      RAM address width; must equal the RAM instance's ADDR_WIDTH
//  DATA_WIDTH  8      byte width
//  FRAME_MAX   40     max stored sentence length in bytes incl. '$' and LF; FRAME_MAX <= 2**ADDR_WIDTH
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous reset, active-high
//  rx_valid     in   1           GPS byte strobe, 1-cycle pulse
//  rx_data      in   DATA_WIDTH  GPS byte
//  ram_we       out  1           RAM port-A write enable (combinational)
//  ram_addr_a   out  ADDR_WIDTH  RAM port-A address (combinational)
//  ram_din_a    out  DATA_WIDTH  RAM port-A write data (= rx_data)
//  ram_addr_b   out  ADDR_WIDTH  RAM port-B address (= rd_ptr)
//  ram_dout_b   in   DATA_WIDTH  RAM port-B data, valid 1 cycle after ram_addr_b is sampled
//  tx_valid     out  1           byte to LoRa tx valid
//  tx_data      out  DATA_WIDTH  byte to LoRa tx
//  tx_ready     in   1           LoRa tx accepts byte when tx_valid & tx_ready
//  frame_len    out  ADDR_WIDTH+1 length of last captured sentence
//  busy         out  1           high in FETCH/LOAD/SEND
//  done_pulse   out  1           1-cycle pulse after last byte accepted
//  ovf_pulse    out  1           1-cycle pulse on sentence overflow
//  drop_pulse   out  1           1-cycle pulse per rx byte dropped while busy
// BEHAVIOUR
//  Reset: state HUNT, wr_ptr=0, rd_ptr=0, tx_valid=0, tx_data=0, frame_len=0, all pulses 0.
//  ram_we is only asserted in the cycle rx_valid is high; the RAM writes on that clock edge.
//  HUNT : rx_valid & rx_data==8'h24 -> write addr 0, wr_ptr<=1, ->CAPT. Other bytes ignored (no write).
//  CAPT : on rx_valid:
//   - rx_data==8'h24        -> resync: write addr 0, wr_ptr<=1, stay CAPT.
//   - else wr_ptr==FRAME_MAX -> no write, ovf_pulse, wr_ptr<=0, ->HUNT.
//   - else write addr wr_ptr, wr_ptr<=wr_ptr+1; if rx_data==8'h0A: frame_len<=wr_ptr+1, rd_ptr<=0, ->FETCH.
//  FETCH: ram_addr_b=rd_ptr sampled by RAM at this edge -> LOAD.
//  LOAD : tx_data<=ram_dout_b, tx_valid<=1 -> SEND.
//  SEND : tx_valid, tx_data held stable until tx_ready. On tx_valid & tx_ready: tx_valid<=0;
//   - rd_ptr==frame_len-1 -> done_pulse, wr_ptr<=0, ->HUNT; else rd_ptr<=rd_ptr+1, ->FETCH.
//  Throughput: 3 cycles/byte with tx_ready tied high. First tx_valid 2 cycles after the LF-write edge.
//  rx_valid in FETCH/LOAD/SEND: byte dropped, ram_we=0, drop_pulse next cycle.
//  frame_len holds its value until the next LF; a sentence exactly FRAME_MAX long (LF at addr FRAME_MAX-1) is legal.
//  Reset mid-SEND: tx_valid low the cycle after rst; the partial frame is abandoned and not resent.
//  ram_addr_b holds rd_ptr in every state; no read side effects.
// STRUCTURE
//  Shared package/header lora_gps_defs: state encoding (HUNT, CAPT, FETCH, LOAD, SEND), NMEA_SOF=8'h24,
//  NMEA_EOF=8'h0A, FRAME_MAX default.
//  One FSM plus wr_ptr/rd_ptr counters; no sub-module. The RAM is instantiated beside this block in the parent.
// TESTING (bench instantiates this block + frame RAM, ADDR_WIDTH=6, FRAME_MAX=40)
//  1 "$GPGGA,1\r\n" (10 B), tx_ready=1 -> RAM[0..9] written, frame_len=10, tx emits same 10 B in order,
//    one done_pulse, first tx_valid 2 cycles after the LF write.
//  2 Same frame, tx_ready low 5 cycles on byte 3 -> tx_valid stays high, tx_data stable, no byte lost or repeated.
//  3 Bytes "xyz" then "$A\n" -> no writes for xyz. Frame "$AB$CD\n" -> resync, frame_len=4, tx "$CD\n".
//  4 '$' + 39 non-LF bytes (wr_ptr=40) then 1 more byte -> ovf_pulse, no tx, back to HUNT.
//    Next "$Z\n" is sent normally.
//  5 '$' + 38 bytes + LF (40 B) -> accepted, frame_len=40, 40 B transmitted.
//  6 rx bytes during SEND -> drop_pulse each, ram_we=0. rst during SEND -> tx_valid=0 next cycle,
//    following sentence transmitted intact.

Source files
------------

// File: rtl/lora_gps_frame_ctrl_pkg.sv
// Shared definitions for the GPS-to-LoRa frame controller: FSM encoding and NMEA framing bytes.
package lora_gps_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_CAPT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4
  } state_e;

  localparam logic [7:0] NMEA_SOF      = 8'h24;
  localparam logic [7:0] NMEA_EOF      = 8'h0A;
  localparam int         FRAME_MAX_DEF = 40;

endpackage

// File: rtl/lora_gps_frame_ctrl.sv
// Captures one NMEA sentence from the GPS UART into the shared frame RAM, then streams it
// to the LoRa transmitter; capture and transmit never overlap.
//
//   state | meaning
//   HUNT  | waiting for '$', nothing stored
//   CAPT  | writing sentence bytes until LF, '$' restarts, overflow aborts
//   FETCH | present rd_ptr to RAM port B
//   LOAD  | latch RAM data into tx_data, raise tx_valid
//   SEND  | hold byte until the transmitter accepts it
module lora_gps_frame_ctrl
  import lora_gps_frame_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_MAX  = FRAME_MAX_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_valid_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_a_o,
  output logic [DATA_WIDTH-1:0] ram_din_a_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_b_i,
  output logic                  tx_valid_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  input  logic                  tx_ready_i,
  output logic [ADDR_WIDTH:0]   frame_len_o,
  output logic                  busy_o,
  output logic                  done_pulse_o,
  output logic                  ovf_pulse_o,
  output logic                  drop_pulse_o
);

  // wr_ptr is one bit wider than the address so it can sit at FRAME_MAX == 2**ADDR_WIDTH
  localparam logic [ADDR_WIDTH:0] FMAX = (ADDR_WIDTH+1)'(FRAME_MAX);

  state_e                  state_q;
  logic [ADDR_WIDTH:0]     wr_ptr_q;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q;
  logic [ADDR_WIDTH:0]     frame_len_q;
  logic                    tx_valid_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    done_q, ovf_q, drop_q;
  logic                    is_sof, is_eof;

  assign is_sof = (rx_data_i == DATA_WIDTH'(NMEA_SOF));
  assign is_eof = (rx_data_i == DATA_WIDTH'(NMEA_EOF));
  assign busy_o = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_SEND);

  always_comb begin
    ram_we_o     = 1'b0;
    ram_addr_a_o = '0;
    if (state_q == ST_HUNT) begin
      ram_we_o = rx_valid_i && is_sof;
    end else if (state_q == ST_CAPT) begin
      ram_we_o = rx_valid_i && (is_sof || (wr_ptr_q != FMAX));
      if (!is_sof) ram_addr_a_o = wr_ptr_q[ADDR_WIDTH-1:0];
    end
  end

  assign ram_din_a_o  = rx_data_i;
  assign ram_addr_b_o = rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HUNT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      drop_q <= rx_valid_i && busy_o;
      case (state_q)
        ST_HUNT: begin
          if (rx_valid_i && is_sof) begin
            wr_ptr_q <= (ADDR_WIDTH+1)'(1);
            state_q  <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (rx_valid_i) begin
            if (is_sof) begin
              wr_ptr_q <= (ADDR_WIDTH+1)'(1);
            end else if (wr_ptr_q == FMAX) begin
              ovf_q    <= 1'b1;
              wr_ptr_q <= '0;
              state_q  <= ST_HUNT;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (is_eof) begin
                frame_len_q <= wr_ptr_q + 1'b1;
                rd_ptr_q    <= '0;
                state_q     <= ST_FETCH;
              end
            end
          end
        end
        ST_FETCH: state_q <= ST_LOAD;
        ST_LOAD: begin
          tx_data_q  <= ram_dout_b_i;
          tx_valid_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_valid_q && tx_ready_i) begin
            tx_valid_q <= 1'b0;
            if ({1'b0, rd_ptr_q} == frame_len_q - 1'b1) begin
              done_q   <= 1'b1;
              wr_ptr_q <= '0;
              state_q  <= ST_HUNT;
            end else begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
              state_q  <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;
  assign frame_len_o  = frame_len_q;
  assign done_pulse_o = done_q;
  assign ovf_pulse_o  = ovf_q;
  assign drop_pulse_o = drop_q;

endmodule

// File: tb/tb_lora_gps_frame_ctrl.sv
// Directed bench for lora_gps_frame_ctrl with a behavioural frame RAM beside it.
module tb_lora_gps_frame_ctrl;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_dout_b;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic [AW:0]   frame_len;
  logic          busy, done_pulse, ovf_pulse, drop_pulse;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] txq [$];
  int wr_cnt = 0, done_cnt = 0, ovf_cnt = 0, drop_cnt = 0;

  always #5 clk = ~clk;

  lora_gps_frame_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_MAX(40)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .ram_we_o(ram_we), .ram_addr_a_o(ram_addr_a), .ram_din_a_o(ram_din_a),
    .ram_addr_b_o(ram_addr_b), .ram_dout_b_i(ram_dout_b),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .frame_len_o(frame_len), .busy_o(busy), .done_pulse_o(done_pulse),
    .ovf_pulse_o(ovf_pulse), .drop_pulse_o(drop_pulse)
  );

  // frame RAM: registered port-B address
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  always @(posedge clk) begin
    if (ram_we) wr_cnt <= wr_cnt + 1;
    if (done_pulse) done_cnt <= done_cnt + 1;
    if (ovf_pulse) ovf_cnt <= ovf_cnt + 1;
    if (drop_pulse) drop_cnt <= drop_cnt + 1;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive_byte(s[i]);
  endtask

  task automatic wait_done(input string name, input int start);
    int n = 0;
    while (done_cnt == start && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_cnt == start) begin
      fails++;
      $display("FAIL %s: done_pulse not seen within 500 cycles", name);
    end
  endtask

  task automatic check_tx(input string name, input string exp);
    int bad = -1;
    tests++;
    for (int i = 0; i < exp.len() && i < txq.size(); i++)
      if (bad < 0 && txq[i] !== exp[i]) bad = i;
    if (txq.size() != exp.len() || bad >= 0) begin
      fails++;
      $display("FAIL %s: tx got %0d bytes (first bad index %0d), expected %0d bytes",
               name, txq.size(), bad, exp.len());
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    check_val("reset tx_valid", int'(tx_valid), 0);
    check_val("reset tx_data", int'(tx_data), 0);
    check_val("reset frame_len", int'(frame_len), 0);
    check_val("reset busy", int'(busy), 0);
    check_val("reset pulses", int'({done_pulse, ovf_pulse, drop_pulse}), 0);
    check_val("reset ram_addr_b", int'(ram_addr_b), 0);
  endtask

  task automatic test_basic();
    string f = "$GPGGA,1\r\n";
    int d0 = done_cnt;
    int w0 = wr_cnt;
    int ok = 1;
    txq.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 9; i++) drive_byte(f[i]);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h0A;
    @(negedge clk);
    rx_valid = 1'b0;
    check_val("basic tx_valid +1", int'(tx_valid), 0);
    check_val("basic busy +1", int'(busy), 1);
    @(negedge clk);
    check_val("basic tx_valid +2 edge pending", int'(tx_valid), 0);
    @(negedge clk);
    check_val("basic first tx_valid", int'(tx_valid), 1);
    check_val("basic first tx_data", int'(tx_data), 8'h24);
    check_val("basic frame_len", int'(frame_len), 10);
    check_val("basic writes", wr_cnt - w0, 10);
    for (int i = 0; i < 10; i++) if (mem[i] !== f[i]) ok = 0;
    check_val("basic ram contents", ok, 1);
    wait_done("basic done", d0);
    check_tx("basic tx stream", f);
    @(negedge clk);
    check_val("basic one done", done_cnt - d0, 1);
  endtask

  task automatic test_backpressure();
    string f = "$GPGGA,1\r\n";
    int d0 = done_cnt;
    int n = 0;
    int stable = 1;
    logic [7:0] held;
    txq.delete();
    tx_ready = 1'b1;
    send_str(f);
    while (!(txq.size() == 2 && tx_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    held = tx_data;
    check_val("bp held byte", int'(held), int'(f[2]));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== held) stable = 0;
    end
    check_val("bp valid/data stable", stable, 1);
    check_val("bp no accept while stalled", txq.size(), 2);
    tx_ready = 1'b1;
    wait_done("bp done", d0);
    check_tx("bp tx stream", f);
  endtask

  task automatic test_resync();
    int w0 = wr_cnt;
    int d0;
    txq.delete();
    send_str("xyz");
    @(negedge clk);
    check_val("resync junk writes", wr_cnt - w0, 0);
    check_val("resync junk busy", int'(busy), 0);
    d0 = done_cnt;
    send_str("$A\n");
    wait_done("resync short done", d0);
    check_tx("resync short tx", "$A\n");
    check_val("resync short len", int'(frame_len), 3);
    txq.delete();
    d0 = done_cnt;
    send_str("$AB$CD\n");
    wait_done("resync done", d0);
    check_val("resync frame_len", int'(frame_len), 4);
    check_tx("resync tx", "$CD\n");
  endtask

  task automatic test_overflow();
    int w0 = wr_cnt;
    int o0 = ovf_cnt;
    int d0;
    txq.delete();
    drive_byte(8'h24);
    for (int i = 0; i < 39; i++) drive_byte(8'h61);
    drive_byte(8'h62);
    repeat (6) @(negedge clk);
    check_val("ovf pulses", ovf_cnt - o0, 1);
    check_val("ovf writes", wr_cnt - w0, 40);
    check_val("ovf busy", int'(busy), 0);
    check_val("ovf no tx", txq.size(), 0);
    check_val("ovf frame_len held", int'(frame_len), 4);
    d0 = done_cnt;
    send_str("$Z\n");
    wait_done("ovf recover done", d0);
    check_tx("ovf recover tx", "$Z\n");
  endtask

  task automatic test_max_len();
    string f = "$";
    int d0 = done_cnt;
    int o0 = ovf_cnt;
    txq.delete();
    for (int i = 0; i < 38; i++) f = {f, string'(8'h41 + 8'(i % 26))};
    f = {f, "\n"};
    send_str(f);
    wait_done("max done", d0);
    check_val("max frame_len", int'(frame_len), 40);
    check_val("max no ovf", ovf_cnt - o0, 0);
    check_tx("max tx", f);
  endtask

  task automatic test_drop_and_reset();
    int n = 0;
    int w0;
    int p0;
    int d0;
    txq.delete();
    tx_ready = 1'b0;
    send_str("$GPS\n");
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("drop in SEND", int'(tx_valid), 1);
    w0 = wr_cnt;
    p0 = drop_cnt;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h24;
    #1;
    check_val("drop ram_we low", int'(ram_we), 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check_val("drop pulse next cycle", int'(drop_pulse), 1);
    @(negedge clk);
    check_val("drop pulse one cycle", int'(drop_pulse), 0);
    drive_byte(8'h51);
    @(negedge clk);
    check_val("drop count", drop_cnt - p0, 2);
    check_val("drop no writes", wr_cnt - w0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst mid-send tx_valid", int'(tx_valid), 0);
    check_val("rst mid-send busy", int'(busy), 0);
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst no resend", txq.size(), 0);
    d0 = done_cnt;
    send_str("$OK\n");
    wait_done("after rst done", d0);
    check_tx("after rst tx", "$OK\n");
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_resync();
    test_overflow();
    test_max_len();
    test_drop_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
